// File: rtl/regfile_wb_sink.sv
// Architectural register file with two registered read ports, a write-back write port and a
// per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_wb_sink #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dst,
  output logic              rsv_ready,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              wb_orphan
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][DATA_W-1:0] reg_vals;
  logic [NUM_REGS-1:0][PEND_W-1:0] pend_vals;
  logic                            rsv_accept;
  logic                            orphan_next;
  logic [DATA_W-1:0]               rd_data_a_reg, rd_data_b_reg;
  logic [DATA_W-1:0]               rd_data_a_next, rd_data_b_next;
  logic                            wb_orphan_reg;
  logic                            byp_a, byp_b;
  logic                            retire_a, retire_b;

  // A retiring write-back to a saturated register frees the slot it would otherwise block.
  assign rsv_ready  = !((pend_vals[rsv_dst] == PEND_MAX) && !(wr_en && (wr_dst == rsv_dst)));
  assign rsv_accept = rsv_en & rsv_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == 0) begin : g_zero
        assign reg_vals[gi]  = '0;
        assign pend_vals[gi] = '0;
      end else begin : g_live
        logic [DATA_W-1:0] value_reg;
        logic [PEND_W-1:0] pend_reg, pend_next;
        logic              wb_hit, rsv_hit;

        assign wb_hit  = wr_en && (wr_dst == ADDR_W'(gi));
        assign rsv_hit = rsv_accept && (rsv_dst == ADDR_W'(gi));

        always_comb begin
          pend_next = pend_reg;
          if (wb_hit && !rsv_hit) begin
            if (pend_reg != '0) pend_next = pend_reg - PEND_W'(1);
          end else if (rsv_hit && !wb_hit) begin
            pend_next = pend_reg + PEND_W'(1);
          end
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            value_reg <= '0;
            pend_reg  <= '0;
          end else begin
            if (wb_hit) value_reg <= wr_data;
            pend_reg <= pend_next;
          end
        end

        assign reg_vals[gi]  = value_reg;
        assign pend_vals[gi] = pend_reg;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  assign byp_a    = wr_en && (wr_dst == rd_addr_a) && (rd_addr_a != '0);
  assign byp_b    = wr_en && (wr_dst == rd_addr_b) && (rd_addr_b != '0);
  assign retire_a = wr_en && (wr_dst == rd_addr_a) && (pend_vals[rd_addr_a] == PEND_W'(1));
  assign retire_b = wr_en && (wr_dst == rd_addr_b) && (pend_vals[rd_addr_b] == PEND_W'(1));
`else
  assign byp_a    = 1'b0;
  assign byp_b    = 1'b0;
  assign retire_a = 1'b0;
  assign retire_b = 1'b0;
`endif

  assign rd_data_a_next = byp_a ? wr_data : reg_vals[rd_addr_a];
  assign rd_data_b_next = byp_b ? wr_data : reg_vals[rd_addr_b];
  assign orphan_next    = wr_en && (wr_dst != '0) && (pend_vals[wr_dst] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_a_reg <= '0;
      rd_data_b_reg <= '0;
      wb_orphan_reg <= 1'b0;
    end else begin
      rd_data_a_reg <= rd_data_a_next;
      rd_data_b_reg <= rd_data_b_next;
      if (orphan_next) wb_orphan_reg <= 1'b1;
    end
  end

  assign rd_data_a = rd_data_a_reg;
  assign rd_data_b = rd_data_b_reg;
  assign wb_orphan = wb_orphan_reg;
  assign hazard_a  = (rd_addr_a != '0) && (pend_vals[rd_addr_a] != '0) && !retire_a;
  assign hazard_b  = (rd_addr_b != '0) && (pend_vals[rd_addr_b] != '0) && !retire_b;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink: directed scenarios followed by random traffic,
// checked against an array-based reference model.
module tb_regfile_wb_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_dst = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_dst = '0;
  logic        rsv_ready, hazard_a, hazard_b, wb_orphan;

  regfile_wb_sink dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rsv_en(rsv_en), .rsv_dst(rsv_dst), .rsv_ready(rsv_ready),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .wb_orphan(wb_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ra; int rb; logic [15:0] a; logic [15:0] b; } rd_exp_t;
  rd_exp_t exp_q[$];

  int tests = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // Reference model state
  int mregs[16];
  int mpend[16];
  bit morph;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Monitor: a read issued in cycle N is visible once cycle N+1 has started.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
      rd_exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("rd_data_a[%0d]", e.ra), {16'h0, rd_data_a}, {16'h0, e.a});
      chk($sformatf("rd_data_b[%0d]", e.rb), {16'h0, rd_data_b}, {16'h0, e.b});
    end
  end

  task automatic step(input bit rst, input bit wen, input int wd, input int wdat,
                      input int ra, input int rb, input bit ren, input int rdst);
    bit exp_ready, exp_ha, exp_hb, wb, acc;
    rd_exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; wr_en = wen; wr_dst = 4'(wd); wr_data = 16'(wdat);
    rd_addr_a = 4'(ra); rd_addr_b = 4'(rb); rsv_en = ren; rsv_dst = 4'(rdst);
    #1;
    exp_ready = !(mpend[rdst] == 3 && !(wen && wd == rdst));
    exp_ha = (ra != 0) && (mpend[ra] != 0) && !(BYPASS && wen && wd == ra && mpend[ra] == 1);
    exp_hb = (rb != 0) && (mpend[rb] != 0) && !(BYPASS && wen && wd == rb && mpend[rb] == 1);
    chk("rsv_ready", {31'h0, rsv_ready}, {31'h0, exp_ready});
    chk("hazard_a", {31'h0, hazard_a}, {31'h0, exp_ha});
    chk("hazard_b", {31'h0, hazard_b}, {31'h0, exp_hb});
    chk("wb_orphan", {31'h0, wb_orphan}, {31'h0, morph});
    $display("[TB] cyc %0d rst_n=%0b wr=%0b R%0d<=%h rd=R%0d/R%0d rsv=%0b R%0d",
             cyc_cnt, rst, wen, wd, 16'(wdat), ra, rb, ren, rdst);
    e.cyc = cyc_cnt; e.ra = ra; e.rb = rb;
    if (!rst) begin
      e.a = '0; e.b = '0;
    end else begin
      e.a = (BYPASS && wen && wd == ra && ra != 0) ? 16'(wdat) : 16'(mregs[ra]);
      e.b = (BYPASS && wen && wd == rb && rb != 0) ? 16'(wdat) : 16'(mregs[rb]);
    end
    exp_q.push_back(e);
    if (!rst) begin
      foreach (mregs[i]) begin mregs[i] = 0; mpend[i] = 0; end
      morph = 1'b0;
    end else begin
      wb  = wen && wd != 0;
      acc = ren && exp_ready && rdst != 0;
      if (wb && mpend[wd] == 0) morph = 1'b1;
      if (wb) mregs[wd] = wdat & 16'hFFFF;
      if (!(wb && acc && wd == rdst)) begin
        if (wb && mpend[wd] > 0) mpend[wd]--;
        if (acc) mpend[rdst]++;
      end
    end
  endtask

  initial begin
    foreach (mregs[i]) begin mregs[i] = 0; mpend[i] = 0; end
    morph = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 16'h7777, 3, 3, 1, 3);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, i, 15 - i, 0, 0);
    // Basic write/read, R0 hardwired
    step(1, 1, 5, 16'hBEEF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 0, 0, 0);
    step(1, 1, 0, 16'h1234, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 5, 0, 0);
    // Same-cycle write/read
    step(1, 1, 3, 16'h00AA, 0, 0, 0, 0);
    step(1, 1, 3, 16'h0055, 3, 3, 0, 0);
    step(1, 0, 0, 0, 3, 0, 0, 0);
    // Saturate R7, then retire
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 7, 0, 1, 7);
    for (int i = 0; i < 3; i++) step(1, 1, 7, 16'h0700 + i, 7, 7, 1, 7 * (i % 2));
    step(1, 0, 0, 0, 7, 7, 0, 7);
    // Simultaneous reserve + write-back on R9
    step(1, 0, 0, 0, 9, 0, 1, 9);
    step(1, 1, 9, 16'h0909, 9, 0, 1, 9);
    step(1, 0, 0, 0, 9, 9, 0, 0);
    // Orphan write-back to R4
    step(1, 1, 4, 16'h4444, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4, 9, 0, 0);
    step(1, 0, 0, 0, 4, 0, 0, 0);
    // Reset mid-sequence with R7 pending and a concurrent write
    step(1, 0, 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 0, 0, 1, 7);
    step(0, 1, 7, 16'hDEAD, 7, 5, 1, 7);
    step(1, 0, 0, 0, 7, 5, 0, 7);
    step(1, 0, 0, 0, 4, 9, 0, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 15),
           $urandom_range(0, 65535), $urandom_range(0, 15), $urandom_range(0, 15),
           ($urandom_range(0, 2) != 0), $urandom_range(0, 15));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      errors++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
